// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command front end for a 384-bit tweakey / 128-bit block cipher
//
// Purpose:
//   Receives byte-framed commands from a UART and drives a block cipher core.
//   Opcode 0x4B loads a 48-byte key, and opcode 0x50 loads a 16-byte plaintext.
//   Loading a plaintext starts the cipher and returns the 16-byte ciphertext,
//   MSB byte first. Bytes inside a frame are shifted in at the LSB end, so the
//   first byte received ends up in the most significant byte.
//
// Optional feature (macro UART_CMD_KEY_ACK_EN):
//   defined   - after a complete key frame, the single byte 0xA5 is sent back.
//   undefined - a key frame completes silently.
//
// Ports:
//   clk, n_reset        system clock and asynchronous active-low reset
//   rx_data/avail/error received byte, its valid flag and its framing error flag
//   rx_ack              one-cycle pulse that clears rx_avail/rx_error in the UART
//   tx_data/tx_wr       byte to transmit and its one-cycle write strobe
//   tx_busy             UART transmitter busy
//   key, pt             cipher tweakey and plaintext registers
//   start               one-cycle cipher start pulse
//   ct, done            cipher ciphertext and completion (level or pulse)
//   busy                high whenever the controller is not idle

module uart_cmd_ctrl #(
  parameter logic [23:0] RX_TIMEOUT = 24'd1_000_000
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_avail,
  input  logic         rx_error,
  output logic         rx_ack,
  output logic [7:0]   tx_data,
  output logic         tx_wr,
  input  logic         tx_busy,
  output logic [383:0] key,
  output logic [127:0] pt,
  output logic         start,
  input  logic [127:0] ct,
  input  logic         done,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE, RX_KEY, RX_PT, START, WAIT, TX_LOAD, TX_WAIT, TX_GAP
  } state_t;

  state_t         state_q;
  logic [383:0]   key_q;
  logic [383:0]   key_sh_q;
  logic [127:0]   pt_q;
  logic [127:0]   pt_sh_q;
  logic [127:0]   tx_sh_q;
  logic [5:0]     cnt_q;
  logic [23:0]    tmo_q;
  logic           rx_ack_q;
  logic [7:0]     tx_data_q;
  logic           tx_wr_q;
  logic           start_q;
  logic           busy_q;

  // The UART only drops rx_avail after it sees our ack, so the flag is still
  // high in the cycle where the ack is visible. Gating on rx_ack_q prevents
  // the same byte from being consumed twice, and it also keeps acks from
  // ever landing on two consecutive cycles.
  logic rx_take;
  logic err_take;
  assign rx_take  = rx_avail && !rx_ack_q;
  assign err_take = rx_error && !rx_ack_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      key_q     <= '0;
      key_sh_q  <= '0;
      pt_q      <= '0;
      pt_sh_q   <= '0;
      tx_sh_q   <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      rx_ack_q  <= 1'b0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_ack_q <= 1'b0;
      tx_wr_q  <= 1'b0;
      start_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          // Acknowledge anything the UART presents. An errored byte is
          // dropped, and unknown opcodes are dropped.
          if (err_take || rx_take) begin
            rx_ack_q <= 1'b1;
            if (rx_take && !rx_error) begin
              if (rx_data == 8'h4B) begin
                state_q <= RX_KEY;
                cnt_q   <= 6'd48;
                tmo_q   <= '0;
                busy_q  <= 1'b1;
              end else if (rx_data == 8'h50) begin
                state_q <= RX_PT;
                cnt_q   <= 6'd16;
                tmo_q   <= '0;
                busy_q  <= 1'b1;
              end
            end
          end
        end

        RX_KEY, RX_PT: begin
          if (err_take) begin
            // A partial frame stays in the shadow register. The next full
            // frame overwrites every byte of it, so it never needs clearing.
            rx_ack_q <= 1'b1;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end else if (rx_take) begin
            rx_ack_q <= 1'b1;
            tmo_q    <= '0;
            cnt_q    <= cnt_q - 6'd1;
            if (state_q == RX_KEY) begin
              key_sh_q <= {key_sh_q[375:0], rx_data};
              if (cnt_q == 6'd1) begin
                key_q <= {key_sh_q[375:0], rx_data};
`ifdef UART_CMD_KEY_ACK_EN
                tx_sh_q <= {8'hA5, 120'd0};
                cnt_q   <= 6'd1;
                state_q <= TX_LOAD;
`else
                state_q <= IDLE;
                busy_q  <= 1'b0;
`endif
              end
            end else begin
              pt_sh_q <= {pt_sh_q[119:0], rx_data};
              if (cnt_q == 6'd1) begin
                pt_q    <= {pt_sh_q[119:0], rx_data};
                state_q <= START;
              end
            end
          end else if (tmo_q >= RX_TIMEOUT - 24'd1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 24'd1;
          end
        end

        START: begin
          start_q <= 1'b1;
          state_q <= WAIT;
        end

        WAIT: begin
          if (done) begin
            tx_sh_q <= ct;
            cnt_q   <= 6'd16;
            state_q <= TX_LOAD;
          end
        end

        TX_LOAD: begin
          if (!tx_busy) begin
            tx_data_q <= tx_sh_q[127:120];
            tx_wr_q   <= 1'b1;
            state_q   <= TX_GAP;
          end
        end

        // The UART raises tx_busy one cycle after it sees tx_wr. This cycle
        // keeps TX_WAIT from reading the stale low value.
        TX_GAP: state_q <= TX_WAIT;

        TX_WAIT: begin
          if (!tx_busy) begin
            tx_sh_q <= {tx_sh_q[119:0], 8'h00};
            cnt_q   <= cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= TX_LOAD;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ack  = rx_ack_q;
  assign tx_data = tx_data_q;
  assign tx_wr   = tx_wr_q;
  assign key     = key_q;
  assign pt      = pt_q;
  assign start   = start_q;
  assign busy    = busy_q;

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter: RX_TIMEOUT, default 24'd1_000_000, inter-byte timeout in clk cycles while mid-frame.
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 n_reset  in  1  asynchronous, active-low reset.
REQ-004 rx_data  in  8  received byte from UART.
REQ-005 rx_avail  in  1  received byte valid.
REQ-006 rx_error  in  1  UART framing error flag.
REQ-007 rx_ack  out  1  one-cycle pulse clearing rx_avail/rx_error.
REQ-008 tx_data  out  8  byte to transmit.
REQ-009 tx_wr  out  1  one-cycle transmit strobe.
REQ-010 tx_busy  in  1  UART transmitter busy.
REQ-011 key  out  384  cipher tweakey register.
REQ-012 pt  out  128  cipher plaintext register.
REQ-013 start  out  1  one-cycle cipher start pulse.
REQ-014 ct  in  128  cipher ciphertext; valid while done=1.
REQ-015 done  in  1  cipher completion; level or pulse.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, RX_KEY, RX_PT, START, WAIT, TX_LOAD, TX_WAIT, TX_GAP.
REQ-018 IDLE, rx_avail=1: rx_ack pulse; 0x4B -> RX_KEY (count 48); 0x50 -> RX_PT (count 16); other opcodes ignored, stay IDLE.
REQ-019 RX_KEY/RX_PT: each rx_avail=1 byte consumed with one rx_ack pulse and shifted in at LSB end (reg <= {reg, rx_data}), so first byte lands in the MSB byte.
REQ-020 Byte counter 6 bits, decrements per byte; last byte: RX_KEY -> IDLE (or TX_LOAD per REQ-033), RX_PT -> START.
REQ-021 START: start=1 exactly one cycle, then WAIT.
REQ-022 WAIT: done=1 -> capture ct into 128-bit shift register, byte count 16, -> TX_LOAD; no timeout in WAIT.
REQ-023 TX_LOAD: when tx_busy=0, tx_data = MSB byte of shift register, tx_wr=1 one cycle, -> TX_GAP.
REQ-024 TX_GAP: one cycle, masks UART busy-assertion latency, -> TX_WAIT.
REQ-025 TX_WAIT: when tx_busy=0, shift register left by 8, count-1; count 0 -> IDLE, else TX_LOAD; ct transmitted MSB byte first.
REQ-026 rx_error=1 in any RX state: rx_ack pulse, partial data discarded, target register unchanged, -> IDLE.
REQ-027 Timeout counter cleared on every consumed byte; reaching RX_TIMEOUT in RX_KEY/RX_PT -> IDLE, target register unchanged.
REQ-028 Key/pt assembled in shadow shift registers; key/pt outputs update only on last byte of a complete frame.
REQ-029 Bytes arriving outside IDLE/RX states are not acked; held by UART until IDLE.
REQ-030 rx_ack never asserted two consecutive cycles; tx_wr never asserted while tx_busy=1.
REQ-031 done while not in WAIT ignored.

Reset
REQ-032 n_reset low: state IDLE; key, pt, shadow/shift regs, counters, tx_data = 0; rx_ack, tx_wr, start, busy = 0; abort mid-frame or mid-transmit, no further bytes or strobes.

Configuration
REQ-033 Macro UART_CMD_KEY_ACK_EN: defined -> after complete key frame, send single byte 0xA5 via TX_LOAD/TX_GAP/TX_WAIT path (count 1), then IDLE; undefined -> straight to IDLE, no byte sent.

Verification
REQ-034 Send 0x4B + bytes 0x00..0x2F -> key = 0x00_01_..._2F (0x00 in bits 383:376); busy low after; 0xA5 sent only with macro defined.
REQ-035 Send 0x50 + 0x00..0x0F, model done 10 cycles after start, ct=0xF0E1..0F -> one start pulse; 16 tx bytes 0xF0,0xE1,...,0x0F in order, each tx_wr with tx_busy=0.
REQ-036 0x50 + 5 bytes, then idle > RX_TIMEOUT -> IDLE, pt unchanged; next full frame accepted.
REQ-037 rx_error during RX_KEY byte 20 -> rx_ack pulse, IDLE, key unchanged.
REQ-038 Opcode 0x77 -> acked, ignored, no tx_wr, no start.
REQ-039 n_reset asserted during TX of byte 7 -> all outputs zero immediately; no tx_wr after release until a new frame.
